oam_dma_arbiter: RTL and testbench



---
 rtl/nes_bus_pkg.sv | 18 +
 rtl/oam_dma_arbiter.sv | 129 ++++++++++++
 tb/tb_oam_dma_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus definitions.
//   OAM_DMA_ADDR : CPU write address that launches a sprite DMA ($4014)
//   OAMDATA_ADDR : PPU OAM data port, destination of every DMA write ($2004)
//   dma_state_t  : states of the sprite DMA engine
package nes_bus_pkg;

    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA engine and shared-bus arbiter between the CPU core and the bus.
// Passes CPU cycles straight through while idle; a CPU write to
// DMA_TRIG_ADDR halts the CPU and copies 256 bytes from page {cpu_wdata,00}
// to OAM_DATA_ADDR, then returns the bus to the CPU.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cpu_addr/wdata/we     CPU-side bus request
//   cpu_rdata             read data to the CPU (always bus_rdata)
//   cpu_rdy               CPU clock-enable, 0 while a DMA owns the bus
//   bus_addr/wdata/we     shared bus request
//   bus_rdata             shared bus read data, same cycle as bus_addr
//   dma_busy              high whenever the DMA engine is not idle
module oam_dma_arbiter
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_TRIG_ADDR = OAM_DMA_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = OAMDATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    input  logic [7:0]  bus_rdata,
    output logic        dma_busy
);

    dma_state_t state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] idx_q,   idx_d;
    logic [7:0] latch_q, latch_d;
    logic       parity_q, parity_d;
    logic       trigger;

    // Only recognised in IDLE: the CPU is halted otherwise, and any stray
    // write seen while busy must never restart the transfer.
    assign trigger = (state_q == IDLE) && cpu_we && (cpu_addr == DMA_TRIG_ADDR);

    // Next-state logic for the FSM, transfer counter and read latch.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        latch_d  = latch_q;
        parity_d = ~parity_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            // Reads must land on parity-0 cycles: if HALT already sits on
            // parity 1 the next cycle is parity 0, otherwise burn one cycle.
            HALT:  state_d = parity_q ? READ : ALIGN;
            ALIGN: state_d = READ;
            READ: begin
                latch_d = bus_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                // idx is 8 bits and stops at FF, so the address never
                // carries into the page byte.
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            latch_q  <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
            parity_q <= parity_d;
        end
    end

    // Bus mux. Kept apart from the next-state block so that the
    // bus_addr -> memory -> bus_rdata path never appears as a loop.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_we    = cpu_we;
        unique case (state_q)
            IDLE: ;
            HALT, ALIGN: begin
                bus_we = 1'b0;
            end
            READ: begin
                bus_addr = {page_q, idx_q};
                bus_we   = 1'b0;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_wdata = latch_q;
                bus_we    = 1'b1;
            end
            default: begin
                bus_we = 1'b0;
            end
        endcase
    end

    // Decoded from registered state only, so these never glitch.
    assign cpu_rdy   = (state_q == IDLE);
    assign dma_busy  = (state_q != IDLE);
    assign cpu_rdata = bus_rdata;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: flat memory model, scoreboard of expected DMA
// reads, OAM writes and halt lengths, checked by an independent monitor.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic [7:0]  bus_rdata;
    logic        dma_busy;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_rd   [$];
    logic [7:0]  exp_wr   [$];
    int          exp_halt [$];

    int   vectors    = 0;
    int   miscompares = 0;
    int   wr_seen    = 0;
    int   halt_n     = 0;
    int   timeouts   = 0;
    int   cyc        = 0;
    logic rst_q      = 1'b0;
    logic end_req    = 1'b0;
    logic end_done   = 1'b0;

    always #5 clk = ~clk;

    oam_dma_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_rdy   (cpu_rdy),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_rdata (bus_rdata),
        .dma_busy  (dma_busy)
    );

    // Memory is read-only from the bus side; OAM writes are only logged.
    assign bus_rdata = mem[bus_addr];

    // Cycle index since reset; bit 0 is the expected bus parity.
    always @(posedge clk) begin
        rst_q <= rst;
        cyc   <= rst ? 0 : cyc + 1;
    end

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        int e;
        logic [15:0] ea;
        logic [7:0]  ed;
        if (rst_q) begin
            chk(cpu_rdy == 1'b1, "rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
            chk(dma_busy == 1'b0, "rst_dma_busy", 32'(dma_busy), 32'd0);
            chk({bus_we, bus_addr} == {cpu_we, cpu_addr}, "rst_passthru",
                32'({bus_we, bus_addr}), 32'({cpu_we, cpu_addr}));
            halt_n = 0;
        end else begin
            chk(cpu_rdata == bus_rdata, "cpu_rdata", 32'(cpu_rdata), 32'(bus_rdata));
            chk(dma_busy == !cpu_rdy, "dma_busy", 32'(dma_busy), 32'(!cpu_rdy));
            if (cpu_rdy) begin
                if (halt_n != 0) begin
                    if (exp_halt.size() == 0) begin
                        chk(1'b0, "unexpected_halt", 32'(halt_n), 32'd0);
                    end else begin
                        e = exp_halt.pop_front();
                        chk(halt_n == e, "halt_len", 32'(halt_n), 32'(e));
                    end
                    halt_n = 0;
                end
                chk({bus_addr, bus_wdata, bus_we} == {cpu_addr, cpu_wdata, cpu_we}, "passthru",
                    32'({bus_addr, bus_wdata, bus_we}), 32'({cpu_addr, cpu_wdata, cpu_we}));
            end else begin
                halt_n++;
                if (bus_we) begin
                    wr_seen++;
                    chk(bus_addr == 16'h2004, "oam_wr_addr", 32'(bus_addr), 32'h2004);
                    chk(cyc[0] == 1'b1, "oam_wr_parity", 32'(cyc[0]), 32'd1);
                    if (exp_wr.size() == 0) begin
                        chk(1'b0, "unexpected_wr", 32'(bus_wdata), 32'd0);
                    end else begin
                        ed = exp_wr.pop_front();
                        chk(bus_wdata == ed, "oam_wr_data", 32'(bus_wdata), 32'(ed));
                    end
                end else if (bus_addr != cpu_addr) begin
                    chk(cyc[0] == 1'b0, "rd_parity", 32'(cyc[0]), 32'd0);
                    if (exp_rd.size() == 0) begin
                        chk(1'b0, "unexpected_rd", 32'(bus_addr), 32'd0);
                    end else begin
                        ea = exp_rd.pop_front();
                        chk(bus_addr == ea, "rd_addr", 32'(bus_addr), 32'(ea));
                    end
                end
            end
        end
        // An aborted transfer owes nothing more.
        if (rst) begin
            exp_rd.delete();
            exp_wr.delete();
            exp_halt.delete();
        end
        if (end_req && !end_done) begin
            chk(exp_rd.size() == 0, "rd_left", 32'(exp_rd.size()), 32'd0);
            chk(exp_wr.size() == 0, "wr_left", 32'(exp_wr.size()), 32'd0);
            chk(exp_halt.size() == 0, "halt_left", 32'(exp_halt.size()), 32'd0);
            chk(timeouts == 0, "timeouts", 32'(timeouts), 32'd0);
            end_done = 1'b1;
        end
    end

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = w;
        @(posedge clk);
        #1;
    endtask

    // Reference: a transfer of page pg reads {pg,00}..{pg,FF} in order and
    // writes each byte to $2004; the CPU is halted 513 cycles if triggered
    // on an even cycle, 514 if odd.
    task automatic run_dma(input logic [7:0] pg, input bit par, input bit abuse, input bit abort);
        int n;
        int base;
        while (cyc[0] != par) drive(16'h0000, 8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            exp_rd.push_back({pg, 8'(i)});
            exp_wr.push_back(mem[{pg, 8'(i)}]);
        end
        exp_halt.push_back(par ? 514 : 513);
        base = wr_seen;
        drive(16'h4014, pg, 1'b1);
        n = 0;
        forever begin
            if (abuse && n < 100) begin
                cpu_addr  = 16'h4014;
                cpu_wdata = 8'($urandom);
                cpu_we    = 1'b1;
            end else begin
                cpu_addr  = 16'hABCD;
                cpu_wdata = 8'h00;
                cpu_we    = 1'b0;
            end
            @(negedge clk);
            #1;
            if (cpu_rdy) break;
            if (abort && (wr_seen - base) >= 100) break;
            if (n >= 600) begin
                timeouts++;
                $display("FAIL dma_timeout: page %0h still halted after %0d cycles", pg, n);
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        if (abort) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    task automatic random_traffic(input int cycles);
        logic [15:0] a;
        logic        w;
        for (int i = 0; i < cycles; i++) begin
            a = 16'($urandom);
            w = 1'($urandom);
            if (a == 16'h4014) w = 1'b0;
            drive(a, 8'($urandom), w);
        end
    endtask

    initial begin
        logic [7:0] pg;
        rst       = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i) ^ 8'h5A;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        drive(16'h0010, 8'h33, 1'b1);
        drive(16'h4013, 8'h02, 1'b1);
        drive(16'h4015, 8'h02, 1'b1);
        drive(16'h4014, 8'h02, 1'b0);
        repeat (4) drive(16'h0000, 8'h00, 1'b0);

        run_dma(8'h02, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(16'h0000, 8'h00, 1'b0);
        run_dma(8'h02, 1'b1, 1'b0, 1'b0);
        run_dma(8'hFF, 1'b0, 1'b0, 1'b0);

        run_dma(8'h05, 1'b0, 1'b0, 1'b1);
        repeat (5) drive(16'h0000, 8'h00, 1'b0);
        run_dma(8'h03, 1'($urandom), 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            random_traffic(20);
            pg = 8'($urandom);
            if (pg == 8'h40 || pg == 8'hAB) pg = 8'h11;
            run_dma(pg, 1'($urandom), (k == 1), 1'b0);
        end
        random_traffic(10);

        end_req = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
